scaler_arbiter: RTL and testbench
=================================

Name: scaler_arbiter

Overview:
- Round-robin scheduler that lets NUM_REQ result producers (accumulator columns) share one scaler instance.
- Accepts at most one result per cycle and drives the scaler's input_result bus as {valid, data}.
- Tags each issued result with its source id, delayed to line up with the scaler's output_enable.
- Counts results per requester per layer pass. Reports done once every requester has delivered ITEMS_PER_REQ results.

Parameters:
NUM_REQ, 4, number of requesters sharing the scaler
RESULT_WIDTH, 16, width of one result word (matches scaler RESULT_WIDTH)
ITEMS_PER_REQ, 2, results each requester delivers per pass
SCALER_LATENCY, 1, cycles from scaler input_result to its output_enable
ID_WIDTH, $clog2(NUM_REQ) (min 1), source id width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begins a pass
req_valid  in  NUM_REQ  per-requester result valid
req_data  in  NUM_REQ*RESULT_WIDTH  packed results, requester i at [i*RESULT_WIDTH +: RESULT_WIDTH]
req_ready  out  NUM_REQ  one-hot grant (combinational)
scaler_input  out  RESULT_WIDTH+1  to scaler input_result: MSB = valid, LSBs = data (registered)
tag_valid  out  1  high in the cycle the scaler presents the output for a tagged result
tag_id  out  ID_WIDTH  source id of that result
busy  out  1  state == RUN
done  out  1  state == DONE

Behaviour:
- Reset (async, rst_n = 0): state IDLE, rr_ptr 0, all counts 0, scaler_input 0, tag pipeline cleared. Outputs: tag_valid 0, tag_id 0, busy 0, done 0, req_ready 0.
- FSM states:
  - IDLE: start -> RUN.
  - RUN: last required transfer accepted -> DONE.
  - DONE: start -> RUN.
  - start while in RUN is ignored.
- Entering RUN clears all per-requester counts.
- Eligibility: eligible[i] = req_valid[i] && state == RUN && count[i] < ITEMS_PER_REQ.
- Grant: first eligible index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ. req_ready is the one-hot of that index; all zero if nothing is eligible.
- A transfer occurs when req_ready[i] && req_valid[i]. req_valid must not depend on req_ready.
- On each transfer, at the clock edge:
  - scaler_input <= {1'b1, req_data[i]}
  - count[i]++
  - rr_ptr <= (i+1) mod NUM_REQ
  - the tag pipeline is pushed with {1, i}
- With no transfer: scaler_input <= 0, rr_ptr holds, the pipeline is pushed with {0, 0}.
- Throughput is one result per cycle. A requester holding valid for K cycles with no competition gets K consecutive grants, capped at ITEMS_PER_REQ.
- Tag alignment: a transfer in cycle N puts scaler_input valid in cycle N+1. The tag pipeline is SCALER_LATENCY registers deep after that, so tag_valid/tag_id appear in cycle N+1+SCALER_LATENCY, coinciding with scaler output_enable.
- RUN -> DONE happens on the edge where the accepted transfer makes every count[i] equal ITEMS_PER_REQ.
- done stays high in DONE until the next start. The tag pipeline keeps draining in IDLE and DONE.
- Count saturates at ITEMS_PER_REQ; that requester's req_ready stays 0 for the rest of the pass.
- Boundary cases:
  - Reset asserted mid-pass: everything clears immediately. Results already sent to the scaler still emerge from the scaler, but with tag_valid 0.
  - start in the same cycle as the final transfer (already in RUN): the transfer completes, state -> DONE, start is ignored.
  - NUM_REQ = 1: rr_ptr stays 0.

Decomposition:
- Shared package holds: the state enum (IDLE/RUN/DONE) and the id-width helper function.
- One natural sub-module: rr_arbiter. Combinational masked round-robin pick, with inputs eligible and rr_ptr, outputs grant one-hot, grant_id and any.
- Counters, FSM, output register and tag pipeline stay in scaler_arbiter.

Test Plan:
1. Reset then idle: req_valid = 4'b1111 with no start -> req_ready 0, scaler_input 0, busy 0, done 0.
2. start, all four valid continuously, data i*10+count -> grants in order 0,1,2,3,0,1,2,3. scaler_input MSB high for 8 consecutive cycles. tag_id sequence 0,1,2,3,0,1,2,3 with tag_valid 2 cycles after each grant. done rises after the 8th transfer.
3. Only requester 2 valid -> grants on 2 consecutive cycles, then req_ready[2] = 0 (count 2). Remains busy until the others deliver; done only after all eight transfers.
4. Requesters 1 and 3 valid, rr_ptr = 2 -> grant 3 first, then 1. A gap cycle with no valid gives scaler_input = 0 and tag_valid 0 two cycles later.
5. Assert rst_n = 0 mid-pass after 3 transfers -> same-cycle clear: busy 0, counts 0, tag_valid 0. A new start requires the full 8 transfers for done.
6. start pulsed in DONE -> busy 1, counts cleared, a fresh 8-transfer pass completes, done re-asserts.

Source files
------------

// File: rtl/scaler_arbiter_pkg.sv
// Shared types and helpers for the scaler round-robin arbiter.
// Holds the pass FSM encoding and the index-width helper used for parameter defaults.
package scaler_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scaler_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr_i, wrapping.
module scaler_arbiter_rr_arbiter
  import scaler_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  eligible_i,
  input  logic [ID_WIDTH-1:0] rr_ptr_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] grant_id_o,
  output logic                any_o
);

  localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);

  logic [ID_WIDTH:0]   sum_s;
  logic [ID_WIDTH-1:0] idx_s;
  logic                hit_s;

  // Walk candidates starting at the pointer; the first hit wins and masks later ones.
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    sum_s      = '0;
    idx_s      = '0;
    hit_s      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s      = {1'b0, rr_ptr_i} + (ID_WIDTH + 1)'(k);
      idx_s      = (sum_s >= NUM_REQ_W) ? ID_WIDTH'(sum_s - NUM_REQ_W) : ID_WIDTH'(sum_s);
      hit_s      = !any_o && eligible_i[idx_s];
      any_o      = any_o | hit_s;
      grant_o[idx_s] = grant_o[idx_s] | hit_s;
      grant_id_o = hit_s ? idx_s : grant_id_o;
    end
  end

endmodule

// File: rtl/scaler_arbiter.sv
// Shares one scaler among NUM_REQ result producers: round-robin grant, registered scaler
// input, per-pass result counting and a source-id tag aligned with the scaler output.
module scaler_arbiter
  import scaler_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int RESULT_WIDTH   = 16,
  parameter int ITEMS_PER_REQ  = 2,
  parameter int SCALER_LATENCY = 1,
  parameter int ID_WIDTH       = id_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*RESULT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [RESULT_WIDTH:0]           scaler_input,
  output logic                            tag_valid,
  output logic [ID_WIDTH-1:0]             tag_id,
  output logic                            busy,
  output logic                            done
);

  localparam int CNT_W = id_width(ITEMS_PER_REQ + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(ITEMS_PER_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q [NUM_REQ];
  logic [CNT_W-1:0]      count_d [NUM_REQ];
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [RESULT_WIDTH:0] scaler_q, scaler_d;
  logic                  tag_valid_q [SCALER_LATENCY+1];
  logic [ID_WIDTH-1:0]   tag_id_q [SCALER_LATENCY+1];

  logic [NUM_REQ-1:0]      eligible_s;
  logic [NUM_REQ-1:0]      grant_s;
  logic [ID_WIDTH-1:0]     grant_id_s;
  logic                    any_s;
  logic                    last_s;
  logic                    pass_start_s;
  logic [RESULT_WIDTH-1:0] data_s;

  // A requester competes only while a pass runs and its quota is not yet met.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = req_valid[i] && (state_q == ST_RUN) && (count_q[i] < CNT_MAX);
    end
  end

  scaler_arbiter_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .eligible_i (eligible_s),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (grant_s),
    .grant_id_o (grant_id_s),
    .any_o      (any_s)
  );

  assign req_ready = grant_s;

  // The pass ends on the transfer that fills the last open quota; data is a one-hot mux.
  always_comb begin
    last_s = any_s;
    data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      last_s = last_s && ((count_q[i] + CNT_W'(grant_s[i])) == CNT_MAX);
      data_s = data_s | (req_data[i*RESULT_WIDTH +: RESULT_WIDTH] & {RESULT_WIDTH{grant_s[i]}});
    end
  end

  // Pass FSM; start is only honoured outside RUN.
  always_comb begin
    state_d      = state_q;
    pass_start_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          pass_start_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next-state for counters, pointer and the scaler input word.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      count_d[i] = pass_start_s ? '0 : (count_q[i] + CNT_W'(grant_s[i]));
    end
    if (any_s) begin
      scaler_d = {1'b1, data_s};
      rr_ptr_d = (grant_id_s == LAST_ID) ? '0 : (grant_id_s + ID_WIDTH'(1));
    end else begin
      scaler_d = '0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State, counters and the tag shift register; tag stage 0 lines up with scaler_input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      scaler_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        count_q[i] <= '0;
      end
      for (int s = 0; s <= SCALER_LATENCY; s++) begin
        tag_valid_q[s] <= 1'b0;
        tag_id_q[s]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      scaler_q <= scaler_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        count_q[i] <= count_d[i];
      end
      tag_valid_q[0] <= any_s;
      tag_id_q[0]    <= any_s ? grant_id_s : '0;
      for (int s = 1; s <= SCALER_LATENCY; s++) begin
        tag_valid_q[s] <= tag_valid_q[s-1];
        tag_id_q[s]    <= tag_id_q[s-1];
      end
    end
  end

  assign scaler_input = scaler_q;
  assign tag_valid    = tag_valid_q[SCALER_LATENCY];
  assign tag_id       = tag_id_q[SCALER_LATENCY];
  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_scaler_arbiter.sv
// Self-checking bench for scaler_arbiter: directed passes plus randomized traffic,
// all compared against a cycle-level behavioural model of the scheduling rules.
module tb_scaler_arbiter;

  localparam int NR  = 4;
  localparam int RW  = 16;
  localparam int IPR = 2;
  localparam int LAT = 1;
  localparam int IDW = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [NR-1:0]     req_valid;
  logic [NR*RW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [RW:0]       scaler_input;
  logic              tag_valid;
  logic [IDW-1:0]    tag_id;
  logic              busy;
  logic              done;

  scaler_arbiter #(
    .NUM_REQ        (NR),
    .RESULT_WIDTH   (RW),
    .ITEMS_PER_REQ  (IPR),
    .SCALER_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .scaler_input (scaler_input),
    .tag_valid    (tag_valid),
    .tag_id       (tag_id),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: pass flags, per-requester counts, pointer, expected scaler word,
  // and a queue of issued tags whose head is what the DUT should present now.
  bit          m_run;
  bit          m_done;
  int          m_cnt [NR];
  int          m_ptr;
  logic [RW:0] m_sin;
  int          q_v[$];
  int          q_id[$];

  logic [NR-1:0] last_ready;
  int            n_xfer;
  int            grant_log[$];
  bit            rand_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick();
    int idx;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (m_run && req_valid[idx] && m_cnt[idx] < IPR) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_done = 1'b0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ptr = 0;
    m_sin = '0;
    q_v.delete();
    q_id.delete();
  endtask

  task automatic model_edge();
    int g;
    bit was_run;
    bit all_full;
    g       = model_pick();
    was_run = m_run;
    if (g >= 0) begin
      m_sin = {1'b1, req_data[g*RW +: RW]};
      m_cnt[g]++;
      m_ptr = (g + 1) % NR;
      q_v.push_back(1);
      q_id.push_back(g);
      all_full = 1'b1;
      foreach (m_cnt[i]) if (m_cnt[i] != IPR) all_full = 1'b0;
      if (all_full) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_sin = '0;
      q_v.push_back(0);
      q_id.push_back(0);
    end
    if (!was_run && start) begin
      m_run  = 1'b1;
      m_done = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end
    if (q_v.size() > LAT + 1) begin
      void'(q_v.pop_front());
      void'(q_id.pop_front());
    end
  endtask

  task automatic check_outputs(input string ph);
    int            g;
    logic [NR-1:0] exp_rdy;
    int            ev;
    int            eid;
    g       = model_pick();
    exp_rdy = (g < 0) ? '0 : (NR'(1) << g);
    ev      = (q_v.size() == LAT + 1) ? q_v[0]  : 0;
    eid     = (q_id.size() == LAT + 1) ? q_id[0] : 0;
    check_val({ph, ".req_ready"},    req_ready,    exp_rdy);
    check_val({ph, ".scaler_input"}, scaler_input, m_sin);
    check_val({ph, ".tag_valid"},    tag_valid,    ev);
    check_val({ph, ".tag_id"},       tag_id,       eid);
    check_val({ph, ".busy"},         busy,         m_run);
    check_val({ph, ".done"},         done,         m_done);
    last_ready = req_ready;
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic st);
    req_valid = v;
    start     = st;
    for (int i = 0; i < NR; i++) begin
      req_data[i*RW +: RW] = rand_data ? RW'($urandom) : RW'(i * 10 + m_cnt[i]);
    end
  endtask

  task automatic cycle(input string ph);
    @(negedge clk);
    check_outputs(ph);
    if (last_ready != '0) begin
      n_xfer++;
      for (int i = 0; i < NR; i++) if (last_ready[i]) grant_log.push_back(i);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic mid_reset(input string ph);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    model_reset();
    #1;
    check_outputs(ph);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_to_done(input string ph, input logic [NR-1:0] v, input logic st);
    int budget;
    budget = 40;
    while (!m_done && budget > 0) begin
      drive(v, st);
      cycle(ph);
      budget--;
    end
    drive(v, 1'b0);
    cycle(ph);
    check_val({ph, ".pass_done"}, done, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rand_data = 1'b0;
    n_xfer    = 0;
    model_reset();
    #1 check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle: valid requests without start get nothing.
    repeat (3) begin
      drive(4'b1111, 1'b0);
      cycle("p1_idle");
    end

    // Full contention: strict rotation 0..3 twice.
    n_xfer = 0;
    grant_log.delete();
    drive(4'b1111, 1'b1);
    cycle("p2");
    run_to_done("p2", 4'b1111, 1'b0);
    check_val("p2.xfers", n_xfer, 8);
    for (int k = 0; k < 8; k++) begin
      check_val("p2.grant_order", (k < grant_log.size()) ? grant_log[k] : -1, k % NR);
    end

    // Lone requester saturates at its quota and the pass stays open.
    n_xfer = 0;
    drive(4'b0100, 1'b1);
    cycle("p3");
    repeat (4) begin
      drive(4'b0100, 1'b0);
      cycle("p3");
    end
    check_val("p3.saturated_ready", last_ready, 4'b0000);
    check_val("p3.lone_xfers", n_xfer, 2);
    check_val("p3.still_busy", busy, 1'b1);
    check_val("p3.not_done", done, 1'b0);
    run_to_done("p3", 4'b1011, 1'b0);
    check_val("p3.xfers", n_xfer, 8);

    // Pointer at 2 with requesters 1 and 3 pending: 3 wins, then 1, then a gap.
    n_xfer = 0;
    drive(4'b0000, 1'b1);
    cycle("p4");
    drive(4'b0010, 1'b0);
    cycle("p4");
    drive(4'b1010, 1'b0);
    cycle("p4");
    check_val("p4.ptr2_grant", last_ready, 4'b1000);
    drive(4'b1010, 1'b0);
    cycle("p4");
    check_val("p4.next_grant", last_ready, 4'b0010);
    repeat (3) begin
      drive(4'b0000, 1'b0);
      cycle("p4_gap");
    end
    run_to_done("p4", 4'b1111, 1'b0);
    check_val("p4.xfers", n_xfer, 8);

    // Reset after three transfers, then a full fresh pass.
    n_xfer = 0;
    drive(4'b1111, 1'b1);
    cycle("p5");
    repeat (3) begin
      drive(4'b1111, 1'b0);
      cycle("p5");
    end
    check_val("p5.pre_reset_xfers", n_xfer, 3);
    mid_reset("p5_rst");
    check_val("p5.busy_after_reset", busy, 1'b0);
    n_xfer = 0;
    drive(4'b1111, 1'b1);
    cycle("p5b");
    run_to_done("p5b", 4'b1111, 1'b0);
    check_val("p5b.xfers", n_xfer, 8);

    // Restart from DONE with start held high, including on the final transfer.
    n_xfer = 0;
    drive(4'b1111, 1'b1);
    cycle("p6");
    check_val("p6.busy_on_restart", busy, 1'b1);
    run_to_done("p6", 4'b1111, 1'b1);
    check_val("p6.xfers", n_xfer, 8);

    // Randomized traffic, stray starts and occasional resets.
    rand_data = 1'b1;
    for (int p = 0; p < 8; p++) begin
      drive(NR'($urandom), 1'b1);
      cycle("rnd");
      for (int c = 0; c < 120; c++) begin
        drive(NR'($urandom), ($urandom_range(0, 15) == 0));
        cycle("rnd");
        if ($urandom_range(0, 149) == 0) mid_reset("rnd_rst");
        if (m_done) break;
      end
    end
    drive(4'b0000, 1'b0);
    repeat (3) cycle("drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
